// File: rtl/dehaze_pkg.sv
// Shared types and helpers for the dehaze pixel pipeline.
package dehaze_pkg;

    localparam int PIX_W        = 8;
    localparam int DARK_LATENCY = 4;

    typedef logic [PIX_W-1:0] pix_t;

    localparam pix_t DARK_INIT = 8'hFF;

    function automatic pix_t min3(input pix_t a, input pix_t b, input pix_t c);
        pix_t t;
        t = (a < b) ? a : b;
        return (t < c) ? t : c;
    endfunction

endpackage

// File: rtl/line_shift_ram.sv
// Single-port line store. The write is clocked, and rd_data shows the word held at addr before
// this cycle's write, so a register capturing rd_data on the same edge gets read-before-write data.
module line_shift_ram
    import dehaze_pkg::*;
#(
    parameter int DEPTH = 640,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  pix_t          din,
    output pix_t          rd_data
);

    pix_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            mem[addr] <= din;
        end
    end

    assign rd_data = mem[addr];

endmodule

// File: rtl/dark_channel_3x3.sv
// Dark channel: per-pixel min(R,G,B) followed by a causal 3x3 minimum filter over two line buffers.
// Output keeps the input sync format, delayed by DARK_LATENCY clocks.
module dark_channel_3x3
    import dehaze_pkg::*;
#(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic [23:0] per_img_rgb,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic [7:0]  post_img_dark,
    output logic        line_len_err
);

    localparam int CW = $clog2(IMG_HDISP + 1);
    localparam int RW = $clog2(IMG_VDISP + 1);
    localparam int AW = $clog2(IMG_HDISP);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_HDISP);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_VDISP);

    logic          vs_d, href_d, vs_low_seen, armed;
    logic          vs_rise, href_fall, col_full;
    logic [CW-1:0] col, col_cur;
    logic [RW-1:0] row, row_cur;

    assign vs_rise   = per_frame_vsync & ~vs_d;
    assign href_fall = ~per_frame_href & href_d;
    // A vsync rise clears the position before the same-cycle pixel is tagged.
    assign col_cur   = vs_rise ? '0 : col;
    assign row_cur   = vs_rise ? '0 : row;
    assign col_full  = (col_cur == COL_MAX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_d         <= 1'b0;
            href_d       <= 1'b0;
            vs_low_seen  <= 1'b0;
            armed        <= 1'b0;
            col          <= '0;
            row          <= '0;
            line_len_err <= 1'b0;
        end else begin
            vs_d   <= per_frame_vsync;
            href_d <= per_frame_href;
            if (!per_frame_vsync) vs_low_seen <= 1'b1;
            if (vs_rise && vs_low_seen) armed <= 1'b1;

            if (href_fall)                        col <= '0;
            else if (per_frame_clken && !col_full) col <= col_cur + CW'(1);
            else                                  col <= col_cur;

            if (vs_rise)                          row <= '0;
            else if (href_fall && row != ROW_MAX) row <= row + RW'(1);

            if ((per_frame_clken && col_full) || (href_fall && col != COL_MAX))
                line_len_err <= 1'b1;
            else if (vs_rise)
                line_len_err <= 1'b0;
        end
    end

    // Stage 1: colour minimum, tagged with position flags ([0]: >=1, [1]: >=2).
    logic          v1, we1;
    pix_t          m1;
    logic [AW-1:0] a1;
    logic [1:0]    tx1, ty1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1  <= 1'b0;
            we1 <= 1'b0;
            m1  <= '0;
            a1  <= '0;
            tx1 <= '0;
            ty1 <= '0;
        end else begin
            v1  <= per_frame_clken;
            we1 <= per_frame_clken & ~col_full;
            m1  <= min3(per_img_rgb[23:16], per_img_rgb[15:8], per_img_rgb[7:0]);
            a1  <= col_cur[AW-1:0];
            tx1 <= {|col_cur[CW-1:1], |col_cur};
            ty1 <= {|row_cur[RW-1:1], |row_cur};
        end
    end

    // Stage 2: line buffers and window shift; win[r][c], r=2 current row, c=2 current column.
    pix_t       lb0_rd, lb1_rd;
    pix_t       win [3][3];
    logic [1:0] tx2, ty2;

    line_shift_ram #(.DEPTH(IMG_HDISP), .AW(AW)) lb0 (
        .clk     (clk),
        .en      (v1 & we1),
        .addr    (a1),
        .din     (lb1_rd),
        .rd_data (lb0_rd)
    );

    line_shift_ram #(.DEPTH(IMG_HDISP), .AW(AW)) lb1 (
        .clk     (clk),
        .en      (v1 & we1),
        .addr    (a1),
        .din     (m1),
        .rd_data (lb1_rd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win[r][c] <= '0;
            tx2 <= '0;
            ty2 <= '0;
        end else if (v1) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb0_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= m1;
            tx2       <= tx1;
            ty2       <= ty1;
        end
    end

    function automatic pix_t tap(input pix_t p, input logic keep);
        return keep ? p : DARK_INIT;
    endfunction

    // Stages 3 and 4: row minima with out-of-image taps forced to DARK_INIT, then column minimum.
    pix_t row_min [3];
    pix_t dark;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 3; r++) row_min[r] <= '0;
            dark <= '0;
        end else begin
            row_min[0] <= min3(tap(win[0][0], tx2[1] & ty2[1]), tap(win[0][1], tx2[0] & ty2[1]),
                               tap(win[0][2], ty2[1]));
            row_min[1] <= min3(tap(win[1][0], tx2[1] & ty2[0]), tap(win[1][1], tx2[0] & ty2[0]),
                               tap(win[1][2], ty2[0]));
            row_min[2] <= min3(tap(win[2][0], tx2[1]), tap(win[2][1], tx2[0]), win[2][2]);
            dark       <= min3(row_min[0], row_min[1], row_min[2]);
        end
    end

    logic [DARK_LATENCY-1:0] vs_sr, hr_sr, ck_sr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_sr <= '0;
            hr_sr <= '0;
            ck_sr <= '0;
        end else begin
            vs_sr <= {vs_sr[DARK_LATENCY-2:0], per_frame_vsync};
            hr_sr <= {hr_sr[DARK_LATENCY-2:0], per_frame_href};
            ck_sr <= {ck_sr[DARK_LATENCY-2:0], per_frame_clken};
        end
    end

    assign post_frame_vsync = vs_sr[DARK_LATENCY-1];
    assign post_frame_href  = hr_sr[DARK_LATENCY-1];
    assign post_frame_clken = ck_sr[DARK_LATENCY-1] & armed;
    assign post_img_dark    = dark;

endmodule

// File: tb/tb_dark_channel_3x3.sv
// Directed and randomized frames from a CMOS-style source, checked against a golden causal 3x3 window model.
module tb_dark_channel_3x3;

    localparam int HD = 8;
    localparam int VD = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsync = 1'b0, href = 1'b0, clken = 1'b0;
    logic [23:0] rgb = '0;
    logic        post_vsync, post_href, post_clken, err;
    logic [7:0]  dark;

    dark_channel_3x3 #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
        .clk              (clk),
        .rst              (rst),
        .per_frame_vsync  (vsync),
        .per_frame_href   (href),
        .per_frame_clken  (clken),
        .per_img_rgb      (rgb),
        .post_frame_vsync (post_vsync),
        .post_frame_href  (post_href),
        .post_frame_clken (post_clken),
        .post_img_dark    (dark),
        .line_len_err     (err)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [23:0] img  [VD][HD+1];
    int          mimg [VD][HD];
    int          row_len [VD];
    logic [3:0]  sh_c = '0, sh_v = '0, sh_h = '0;
    bit          armed_m = 0, vs_prev = 0, vs_low = 0;
    int          expq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rgb_min(input logic [23:0] p);
        int a = p[23:16], b = p[15:8], c = p[7:0];
        int m = a;
        if (b < m) m = b;
        if (c < m) m = c;
        return m;
    endfunction

    function automatic int gold(input int x, input int y);
        int r = 255;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                if (x - dx >= 0 && y - dy >= 0 && mimg[y-dy][x-dx] < r) r = mimg[y-dy][x-dx];
        return r;
    endfunction

    task automatic build_m();
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                mimg[y][x] = rgb_min(img[y][x]);
    endtask

    task automatic fill_const(input logic [23:0] v);
        for (int y = 0; y < VD; y++)
            for (int x = 0; x <= HD; x++)
                img[y][x] = v;
        build_m();
    endtask

    task automatic fill_rand();
        for (int y = 0; y < VD; y++)
            for (int x = 0; x <= HD; x++)
                img[y][x] = 24'($urandom);
        build_m();
    endtask

    task automatic tick();
        sh_c = {sh_c[2:0], clken};
        sh_v = {sh_v[2:0], vsync};
        sh_h = {sh_h[2:0], href};
        if (vsync && !vs_prev && vs_low) armed_m = 1;
        if (!vsync) vs_low = 1;
        vs_prev = vsync;
        @(posedge clk);
        #1;
        chk("vsync_delay", post_vsync, sh_v[3]);
        chk("href_delay", post_href, sh_h[3]);
        chk("clken_delay", post_clken, sh_c[3] & armed_m);
        if (post_clken === 1'b1) begin
            chk("dark_expected_pending", expq.size() > 0, 1);
            if (expq.size() > 0) begin
                int ev = expq.pop_front();
                if (ev >= 0) chk("dark_value", dark, ev);
            end
        end
    endtask

    task automatic mid_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_post_vsync", post_vsync, 0);
        chk("rst_post_href", post_href, 0);
        chk("rst_post_clken", post_clken, 0);
        chk("rst_post_dark", dark, 0);
        chk("rst_err", err, 0);
        rst = 1'b0;
        sh_c = '0; sh_v = '0; sh_h = '0;
        armed_m = 0; vs_prev = 0; vs_low = 0;
        expq.delete();
    endtask

    task automatic run_frame(input bit tight, input int rst_row, input bit exp_clear);
        bit skip = 0, err_known = 1, exp_err = 0;
        vsync = 0; href = 0; clken = 0;
        tick(); tick();
        if (exp_clear) chk("err_hold_until_vsync", err, 1);
        if (!tight) begin
            vsync = 1;
            tick();
            if (exp_clear) chk("err_clear_on_vsync", err, 0);
            tick();
        end
        for (int y = 0; y < VD; y++) begin
            href = 1;
            for (int x = 0; x < row_len[y]; x++) begin
                if (!(tight && y == 0 && x == 0) && $urandom_range(3) == 0) begin
                    clken = 0;
                    tick();
                end
                vsync = 1; clken = 1; rgb = img[y][x];
                tick();
                if (armed_m) expq.push_back((skip || x >= HD) ? -1 : gold(x, y));
                if (rst_row == y && x == 2) begin
                    mid_reset();
                    skip = 1;
                    err_known = 0;
                end
            end
            clken = 0;
            if (err_known && row_len[y] <= HD) chk("err_before_href_fall", err, exp_err);
            href = 0;
            tick(); tick(); tick();
            if (row_len[y] != HD) begin
                exp_err = 1;
                if (row_len[y] < HD) skip = 1;
            end
            if (err_known) chk("err_after_line", err, exp_err);
        end
        repeat (6) tick();
        chk("all_pixels_emitted", expq.size(), 0);
    endtask

    task automatic lens_normal();
        for (int y = 0; y < VD; y++) row_len[y] = HD;
    endtask

    initial begin
        lens_normal();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_vsync", post_vsync, 0);
        chk("reset_href", post_href, 0);
        chk("reset_clken", post_clken, 0);
        chk("reset_dark", dark, 0);
        chk("reset_err", err, 0);
        rst = 1'b0;

        fill_const(24'hC86432);
        run_frame(0, -1, 0);
        run_frame(0, -1, 0);

        fill_const(24'hFFFFFF);
        img[0][0] = 24'h000000;
        build_m();
        run_frame(0, -1, 0);

        fill_const(24'hFFFFFF);
        img[1][3] = 24'h5A0A28;
        build_m();
        run_frame(0, -1, 0);

        repeat (2) begin
            fill_rand();
            run_frame(0, -1, 0);
        end

        fill_const(24'h000000);
        run_frame(0, -1, 0);
        fill_const(24'hFFFFFF);
        run_frame(1, -1, 0);

        fill_rand();
        row_len[2] = 6;
        run_frame(0, -1, 0);
        lens_normal();
        fill_rand();
        run_frame(0, -1, 1);

        fill_rand();
        row_len[2] = HD + 1;
        run_frame(0, -1, 0);
        lens_normal();
        fill_rand();
        run_frame(0, -1, 1);

        fill_rand();
        run_frame(0, 2, 0);
        fill_rand();
        run_frame(0, -1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
